traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
- Parametrised N-approach intersection controller; generational successor to the fixed 4-street, 1-cycle-per-phase controller.
- Adds timed GREEN/YELLOW/ALL-RED phases, an external tick enable, and a clean emergency-preemption sequence.
- Preemption never jumps straight from one green to another; the conflicting green always passes through yellow and all-red first.
- Sits between the timebase (tick generator) and the lamp drivers.

Parameters:
NUM_APPROACH, 4, number of approaches (>=2)
GREEN_CYCLES, 8, ticks per normal green (1..2^CNT_W-1)
YELLOW_CYCLES, 2, ticks per yellow (1..2^CNT_W-1)
ALLRED_CYCLES, 1, ticks per all-red clearance (1..2^CNT_W-1)
CNT_W, 8, phase timer width
IDX_W, $clog2(NUM_APPROACH), approach index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
tick_en  in  1  timebase strobe; FSM and timer advance only on clk edges where tick_en=1
emg_req  in  NUM_APPROACH  per-approach emergency request, level-sensitive; bit i = approach i
light  out  2*NUM_APPROACH  lamp code for approach i at bits [2i+1:2i]: 00 red, 01 yellow, 11 green
active_idx  out  IDX_W  approach currently owning (or last owning) right-of-way
phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=EMG_GREEN
emg_active  out  1  high while phase=EMG_GREEN

Behaviour:
- Registered state: phase, active_idx, timer[CNT_W-1:0], target_idx, tgt_emg. Outputs are decoded from registers only, with no input-to-output combinational path.
- Reset (async): phase=GREEN, active_idx=0, timer=GREEN_CYCLES-1, target_idx=0, tgt_emg=0. This gives light = approach 0 green, all others 00, and emg_active=0.
- Edges with tick_en=0: all state holds.
- Timer rule: on phase entry, load DUR-1. On each tick, if timer!=0 then decrement; if timer==0 then take the phase exit. Each phase therefore lasts exactly DUR ticks.
- Winner: the lowest-index set bit of emg_req. "Req" means emg_req!=0.
- Light decode:
  - GREEN/EMG_GREEN: active approach 11.
  - YELLOW: active approach 01.
  - ALLRED: all 00.
  - Non-active approaches are always 00.
- GREEN, evaluated on each tick:
  - Req and winner==active_idx: go to EMG_GREEN; timer unchanged.
  - Req and winner!=active_idx: go to YELLOW immediately (remaining green is truncated); latch target_idx=winner, tgt_emg=1.
  - No req and timer==0: go to YELLOW; target_idx=(active_idx+1) mod NUM_APPROACH, tgt_emg=0.
  - Otherwise: decrement timer.
- EMG_GREEN:
  - Holds while emg_req[active_idx]=1; timer frozen.
  - If that bit drops and another request exists: go to YELLOW with target=winner, tgt_emg=1.
  - If that bit drops and no request exists: go to YELLOW with target=(active_idx+1) mod N, tgt_emg=0.
- YELLOW:
  - Counts YELLOW_CYCLES, then goes to ALLRED.
  - A new req arriving during YELLOW overwrites target_idx=winner, tgt_emg=1.
  - Yellow is never truncated or extended.
- ALLRED:
  - Counts ALLRED_CYCLES.
  - On exit, target is re-evaluated: if req, the new green is the winner; otherwise the new green is target_idx if tgt_emg=0, or (active_idx+1) mod N if tgt_emg=1 (the request was withdrawn).
  - Enters GREEN with active_idx=new green and timer=GREEN_CYCLES-1. The GREEN rule then promotes to EMG_GREEN on the next tick if the request persists.
- Wrap-around: active_idx=NUM_APPROACH-1 advances to 0.
- Multiple simultaneous requests: the lowest index wins. The others are served in later preemptions if they are still asserted.
- Invariants:
  - At most one approach is non-red at any time.
  - Every green-to-green change passes through >=YELLOW_CYCLES ticks of yellow and >=ALLRED_CYCLES ticks of all-red.
- Reset mid-phase: immediate return to the reset state, regardless of tick_en.

Test Plan:
- Defaults, tick_en=1 always, emg_req=0 → approach 0 is green for ticks 0-7, yellow for 8-9, all-red for 10, then approach 1 green at tick 11; after 44 ticks active_idx wraps back to 0 green.
- tick_en asserted every 3rd clk → each phase spans 3x the clk cycles (green = 24 clks); no state change on non-tick edges.
- Approach 0 green, timer=5; emg_req=4'b0100 held → next tick YELLOW(0) for 2 ticks, ALLRED for 1 tick, GREEN(2), then EMG_GREEN held indefinitely; drop req → YELLOW(2), ALLRED, GREEN(3).
- Approach 1 green; emg_req=4'b0010 → EMG_GREEN on the next tick with no yellow; emg_active=1 until release, then normal yellow and GREEN(2).
- emg_req=4'b1010 while approach 0 is green → winner is approach 1; after 1 is served and bit 1 drops while bit 3 stays high → YELLOW(1), ALLRED, GREEN(3).
- Assert reset during YELLOW of approach 2 → light=8'b00000011, active_idx=0, phase=0 asynchronously; a request withdrawn during ALLRED → green goes to (active+1) mod N.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// N-approach intersection controller with timed green/yellow/all-red phases,
// tick-enabled timebase and emergency preemption via yellow and all-red.
module traffic_phase_controller #(
  parameter int NUM_APPROACH  = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int CNT_W         = 8,
  parameter int IDX_W         = $clog2(NUM_APPROACH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick_en,
  input  logic [NUM_APPROACH-1:0]   emg_req,
  output logic [2*NUM_APPROACH-1:0] light,
  output logic [IDX_W-1:0]          active_idx,
  output logic [1:0]                phase,
  output logic                      emg_active
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_EMG    = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LOAD    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LOAD    = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_APPROACH - 1);

  phase_e                    phase_q, phase_d;
  logic [IDX_W-1:0]          active_q, active_d;
  logic [CNT_W-1:0]          timer_q, timer_d;
  logic [IDX_W-1:0]          target_q, target_d;
  logic                      tgt_emg_q, tgt_emg_d;
  logic [2*NUM_APPROACH-1:0] light_q;
  logic                      emg_q;

  logic                      req;
  logic [IDX_W-1:0]          winner;
  logic [IDX_W-1:0]          next_idx;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_APPROACH-1:0] r);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
      if (r[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [2*NUM_APPROACH-1:0] lamp(input phase_e p,
                                                      input logic [IDX_W-1:0] a);
    logic [2*NUM_APPROACH-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
      if (a == IDX_W'(i)) begin
        case (p)
          PH_GREEN, PH_EMG: l[2*i +: 2] = 2'b11;
          PH_YELLOW:        l[2*i +: 2] = 2'b01;
          default:          l[2*i +: 2] = 2'b00;
        endcase
      end
    end
    return l;
  endfunction

  assign req      = |emg_req;
  assign winner   = lowest_set(emg_req);
  assign next_idx = (active_q == LAST_IDX) ? '0 : active_q + IDX_W'(1);

  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    timer_d   = timer_q;
    target_d  = target_q;
    tgt_emg_d = tgt_emg_q;
    case (phase_q)
      PH_GREEN: begin
        if (req && winner == active_q) begin
          phase_d = PH_EMG;
        end else if (req) begin
          phase_d   = PH_YELLOW;
          timer_d   = Y_LOAD;
          target_d  = winner;
          tgt_emg_d = 1'b1;
        end else if (timer_q == '0) begin
          phase_d   = PH_YELLOW;
          timer_d   = Y_LOAD;
          target_d  = next_idx;
          tgt_emg_d = 1'b0;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      PH_EMG: begin
        if (!emg_req[active_q]) begin
          phase_d   = PH_YELLOW;
          timer_d   = Y_LOAD;
          target_d  = req ? winner : next_idx;
          tgt_emg_d = req;
        end
      end
      PH_YELLOW: begin
        // A late request only retargets; yellow length is never altered.
        if (req) begin
          target_d  = winner;
          tgt_emg_d = 1'b1;
        end
        if (timer_q == '0) begin
          phase_d = PH_ALLRED;
          timer_d = A_LOAD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        if (timer_q == '0) begin
          phase_d = PH_GREEN;
          timer_d = G_LOAD;
          if (req)            active_d = winner;
          else if (tgt_emg_q) active_d = next_idx;
          else                active_d = target_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
    endcase
  end

  // Lamp and emergency outputs are registered from next state so they
  // change on the same edge as the phase itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_GREEN;
      active_q  <= '0;
      timer_q   <= G_LOAD;
      target_q  <= '0;
      tgt_emg_q <= 1'b0;
      light_q   <= lamp(PH_GREEN, '0);
      emg_q     <= 1'b0;
    end else if (tick_en) begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      timer_q   <= timer_d;
      target_q  <= target_d;
      tgt_emg_q <= tgt_emg_d;
      light_q   <= lamp(phase_d, active_d);
      emg_q     <= (phase_d == PH_EMG);
    end
  end

  assign light      = light_q;
  assign active_idx = active_q;
  assign phase      = phase_q;
  assign emg_active = emg_q;

endmodule
